// File: rtl/sound_responder.sv
// sound_responder: cleans the microphone input (invert option, 2-flop
// synchroniser, debouncer), detects sound onset and answers with a delayed
// buzzer beep train followed by a cooldown. All outputs are registered.
module sound_responder #(
  parameter int TICK_CYCLES     = 25000000,
  parameter int WAIT_TICKS      = 5,
  parameter int BEEPS           = 3,
  parameter int BEEP_TICKS      = 1,
  parameter int COOLDOWN_TICKS  = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MIC_ACTIVE_HIGH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mic,
  input  logic                       enable,
  output logic                       buzzer,
  output logic                       heard,
  output logic                       busy,
  output logic [$clog2(BEEPS+1)-1:0] beep_count
);

  localparam int CW   = $clog2(TICK_CYCLES);
  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BW   = $clog2(BEEPS + 1);
  localparam int MAXW = (WAIT_TICKS > BEEP_TICKS) ? WAIT_TICKS : BEEP_TICKS;
  localparam int MAXT = (MAXW > COOLDOWN_TICKS) ? MAXW : COOLDOWN_TICKS;
  localparam int TW   = $clog2(MAXT + 1);

  localparam logic [CW-1:0] TICK_LAST     = CW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST       = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST     = TW'((WAIT_TICKS > 0) ? WAIT_TICKS - 1 : 0);
  localparam logic [TW-1:0] BEEP_LAST     = TW'(BEEP_TICKS - 1);
  localparam logic [TW-1:0] COOLDOWN_LAST = TW'((COOLDOWN_TICKS > 0) ? COOLDOWN_TICKS - 1 : 0);
  localparam logic [BW-1:0] BEEPS_MAX     = BW'(BEEPS);
  localparam logic          MIC_INVERT    = (MIC_ACTIVE_HIGH == 0);

  typedef enum logic [2:0] {
    ST_LISTENING,
    ST_WAITING,
    ST_BEEP_ON,
    ST_BEEP_OFF,
    ST_COOLDOWN
  } state_t;

  state_t          state_reg, state_next;
  logic            mic_meta_reg, mic_sync_reg;
  logic            snd_clean_reg, snd_rise_reg;
  logic [DW-1:0]   db_cnt_reg;
  logic [CW-1:0]   tick_cnt_reg;
  logic [TW-1:0]   ticks_reg;
  logic            tick;
  logic            state_change;
  logic            buzzer_reg, heard_reg, busy_reg;
  logic [BW-1:0]   beep_count_reg;
  logic            buzzer_next, heard_next, busy_next;
  logic [BW-1:0]   beep_count_next;

  assign tick         = (tick_cnt_reg == TICK_LAST);
  assign state_change = (state_next != state_reg);

  assign buzzer     = buzzer_reg;
  assign heard      = heard_reg;
  assign busy       = busy_reg;
  assign beep_count = beep_count_reg;

  // Polarity correction and two-flop synchroniser for the asynchronous mic pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mic_meta_reg <= 1'b0;
      mic_sync_reg <= 1'b0;
    end else begin
      mic_meta_reg <= mic ^ MIC_INVERT;
      mic_sync_reg <= mic_meta_reg;
    end
  end

  // Debouncer: accept a new level after enough consecutive differing samples;
  // snd_rise_reg marks the onset for exactly one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snd_clean_reg <= 1'b0;
      snd_rise_reg  <= 1'b0;
      db_cnt_reg    <= '0;
    end else begin
      snd_rise_reg <= 1'b0;
      if (mic_sync_reg != snd_clean_reg) begin
        if (db_cnt_reg == DB_LAST) begin
          snd_clean_reg <= mic_sync_reg;
          snd_rise_reg  <= mic_sync_reg;
          db_cnt_reg    <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end
  end

  // Cycle and tick counters, both restarted whenever the state changes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_reg <= '0;
      ticks_reg    <= '0;
    end else if (state_change) begin
      tick_cnt_reg <= '0;
      ticks_reg    <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
      ticks_reg    <= ticks_reg + 1'b1;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_LISTENING;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a low enable outside LISTENING aborts the response.
  // With WAIT_TICKS=0 the WAITING state lasts a single cycle so the first
  // beep starts one cycle after heard.
  always_comb begin
    state_next = state_reg;
    if (!enable && (state_reg != ST_LISTENING)) begin
      state_next = ST_LISTENING;
    end else begin
      case (state_reg)
        ST_LISTENING: begin
          if (snd_rise_reg && enable) state_next = ST_WAITING;
        end
        ST_WAITING: begin
          if ((WAIT_TICKS == 0) || (tick && (ticks_reg == WAIT_LAST)))
            state_next = ST_BEEP_ON;
        end
        ST_BEEP_ON: begin
          if (tick && (ticks_reg == BEEP_LAST)) state_next = ST_BEEP_OFF;
        end
        ST_BEEP_OFF: begin
          if (tick && (ticks_reg == BEEP_LAST)) begin
            if (beep_count_reg < BEEPS_MAX)  state_next = ST_BEEP_ON;
            else if (COOLDOWN_TICKS == 0)    state_next = ST_LISTENING;
            else                             state_next = ST_COOLDOWN;
          end
        end
        ST_COOLDOWN: begin
          if ((COOLDOWN_TICKS == 0) || (tick && (ticks_reg == COOLDOWN_LAST)))
            state_next = ST_LISTENING;
        end
        default: state_next = ST_LISTENING;
      endcase
    end
  end

  // Output logic: next values derived from the transition being taken
  always_comb begin
    heard_next      = (state_reg == ST_LISTENING) && (state_next == ST_WAITING);
    buzzer_next     = (state_next == ST_BEEP_ON);
    busy_next       = (state_next != ST_LISTENING);
    beep_count_next = beep_count_reg;
    if (state_next == ST_LISTENING) begin
      beep_count_next = '0;
    end else if ((state_reg == ST_BEEP_ON) && (state_next == ST_BEEP_OFF) &&
                 (beep_count_reg != BEEPS_MAX)) begin
      beep_count_next = beep_count_reg + 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buzzer_reg     <= 1'b0;
      heard_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      beep_count_reg <= '0;
    end else begin
      buzzer_reg     <= buzzer_next;
      heard_reg      <= heard_next;
      busy_reg       <= busy_next;
      beep_count_reg <= beep_count_next;
    end
  end

endmodule

// File: tb/tb_sound_responder.sv
// Bench for sound_responder: two instances (active-high mic and inverted
// polarity fed with the complemented mic) checked every cycle against a
// timeline model of the response, plus literal timing expectations.
module tb_sound_responder;

  localparam int TC = 4;
  localparam int WT = 2;
  localparam int NB = 3;
  localparam int BT = 1;
  localparam int CD = 2;
  localparam int DB = 4;
  localparam int P  = BT * TC;                  // cycles per beep phase
  localparam int W  = WT * TC;                  // cycles from heard to first beep
  localparam int L  = W + NB * 2 * P + CD * TC; // cycles busy stays high

  localparam int SEL_HEARD  = 0;
  localparam int SEL_BUZZER = 1;
  localparam int SEL_BUSY   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mic = 1'b0;
  logic enable = 1'b1;
  logic mic_n;
  logic buzzer_a, heard_a, busy_a;
  logic buzzer_b, heard_b, busy_b;
  logic [1:0] count_a, count_b;

  assign mic_n = ~mic;

  always #5 clk = ~clk;

  sound_responder #(
    .TICK_CYCLES(TC), .WAIT_TICKS(WT), .BEEPS(NB), .BEEP_TICKS(BT),
    .COOLDOWN_TICKS(CD), .DEBOUNCE_CYCLES(DB), .MIC_ACTIVE_HIGH(1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .mic(mic), .enable(enable),
    .buzzer(buzzer_a), .heard(heard_a), .busy(busy_a), .beep_count(count_a)
  );

  sound_responder #(
    .TICK_CYCLES(TC), .WAIT_TICKS(WT), .BEEPS(NB), .BEEP_TICKS(BT),
    .COOLDOWN_TICKS(CD), .DEBOUNCE_CYCLES(DB), .MIC_ACTIVE_HIGH(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .mic(mic_n), .enable(enable),
    .buzzer(buzzer_b), .heard(heard_b), .busy(busy_b), .beep_count(count_b)
  );

  // ---------------- behavioural model ----------------
  // m_t = cycles elapsed since heard (-1 when listening); outputs are a
  // pure function of m_t.
  int m_s1 = 0, m_s2 = 0, m_clean = 0, m_run = 0, m_rise = 0;
  int m_t = -1;

  always @(posedge clk or posedge rst) begin
    int nrise;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_clean = 0; m_run = 0; m_rise = 0; m_t = -1;
    end else begin
      if (m_t < 0) begin
        if ((m_rise != 0) && enable) m_t = 0;
      end else if (!enable) begin
        m_t = -1;
      end else begin
        m_t = m_t + 1;
        if (m_t >= L) m_t = -1;
      end
      nrise = 0;
      if (m_s2 != m_clean) begin
        m_run = m_run + 1;
        if (m_run == DB) begin
          m_clean = m_s2;
          m_run   = 0;
          nrise   = m_clean;
        end
      end else begin
        m_run = 0;
      end
      m_s2   = m_s1;
      m_s1   = int'(mic);
      m_rise = nrise;
    end
  end

  function automatic void expect_outs(input int t, output logic eb, output logic eh,
                                      output logic ey, output logic [1:0] ec);
    int u, n;
    eb = 1'b0;
    eh = (t == 0);
    ey = (t >= 0);
    ec = 2'd0;
    if (t >= W) begin
      u = t - W;
      if (u < NB * 2 * P) eb = ((u % (2 * P)) < P);
      n = (u + P) / (2 * P);
      if (n > NB) n = NB;
      ec = 2'(n);
    end
  endfunction

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mic_left = 0;
  int buz_rises = 0;
  int heard_cnt = 0;
  logic buz_prev = 1'b0;

  task automatic cmp(input string name, input logic bz, input logic h, input logic by,
                     input logic [1:0] c, input logic ebz, input logic eh,
                     input logic eby, input logic [1:0] ec);
    checks++;
    if ((bz !== ebz) || (h !== eh) || (by !== eby) || (c !== ec)) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cyc=%0d buzzer=%b/%b heard=%b/%b busy=%b/%b beep_count=%0d/%0d (actual/required)",
                 name, cyc, bz, ebz, h, eh, by, eby, c, ec);
    end
  endtask

  task automatic lit_check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // advance one cycle, release timed mic pulses, compare both DUTs to model
  task automatic step();
    logic eb, eh, ey;
    logic [1:0] ec;
    @(negedge clk);
    cyc++;
    if (mic_left > 0) begin
      mic_left--;
      if (mic_left == 0) mic = 1'b0;
    end
    expect_outs(m_t, eb, eh, ey, ec);
    cmp("cycle_pos", buzzer_a, heard_a, busy_a, count_a, eb, eh, ey, ec);
    cmp("cycle_inv", buzzer_b, heard_b, busy_b, count_b, eb, eh, ey, ec);
    if (buzzer_a && !buz_prev) buz_rises++;
    buz_prev = buzzer_a;
    if (heard_a) heard_cnt++;
  endtask

  task automatic wait_until(input int sel, input logic val, input int bound, output int n);
    logic cur;
    n = -1;
    for (int k = 1; k <= bound; k++) begin
      step();
      case (sel)
        SEL_HEARD:  cur = heard_a;
        SEL_BUZZER: cur = buzzer_a;
        default:    cur = busy_a;
      endcase
      if (cur == val) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic pulse(input int len);
    mic = 1'b1;
    mic_left = len;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, hc, en_left;

    // reset held while mic toggles
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mic = ~mic;
      step();
    end
    lit_check("reset_busy", int'(busy_a), 0);
    lit_check("reset_count", int'(count_a), 0);
    mic = 1'b0;
    rst = 1'b0;
    base = heard_cnt;
    repeat (12) step();
    lit_check("post_reset_quiet", heard_cnt - base, 0);

    // clean sound, 30 cycles
    base = buz_rises;
    pulse(30);
    wait_until(SEL_HEARD, 1'b1, 20, n);
    lit_check("heard_latency", n, 7);
    lit_check("inv_heard", int'(heard_b), 1);
    hc = cyc;
    wait_until(SEL_BUZZER, 1'b1, 20, n);
    lit_check("first_beep_delay", n, 8);
    wait_until(SEL_BUZZER, 1'b0, 20, n);
    lit_check("beep_high_len", n, 4);
    lit_check("count_after_beep1", int'(count_a), 1);
    wait_until(SEL_BUZZER, 1'b1, 20, n);
    lit_check("beep_low_len", n, 4);
    wait_until(SEL_BUSY, 1'b0, 60, n);
    lit_check("busy_duration", cyc - hc, 40);
    lit_check("beeps_clean", buz_rises - base, 3);
    repeat (30) step();

    // glitch rejection
    base = heard_cnt;
    pulse(3);
    repeat (20) step();
    lit_check("glitch_heard", heard_cnt - base, 0);
    lit_check("glitch_busy", int'(busy_a), 0);

    // retrigger during BEEP_OFF is ignored
    base = buz_rises;
    pulse(10);
    wait_until(SEL_HEARD, 1'b1, 20, n);
    wait_until(SEL_BUZZER, 1'b1, 20, n);
    wait_until(SEL_BUZZER, 1'b0, 20, n);
    pulse(10);
    wait_until(SEL_BUSY, 1'b0, 60, n);
    lit_check("beeps_retrigger", buz_rises - base, 3);
    repeat (3) step();
    pulse(10);
    wait_until(SEL_HEARD, 1'b1, 20, n);
    lit_check("fresh_heard_latency", n, 7);
    wait_until(SEL_BUSY, 1'b0, 60, n);
    repeat (20) step();

    // abort during second BEEP_ON
    pulse(10);
    wait_until(SEL_HEARD, 1'b1, 20, n);
    wait_until(SEL_BUZZER, 1'b1, 20, n);
    wait_until(SEL_BUZZER, 1'b0, 20, n);
    wait_until(SEL_BUZZER, 1'b1, 20, n);
    step();
    enable = 1'b0;
    step();
    lit_check("abort_buzzer", int'(buzzer_a), 0);
    lit_check("abort_busy", int'(busy_a), 0);
    lit_check("abort_count", int'(count_a), 0);
    enable = 1'b1;
    repeat (5) step();
    pulse(10);
    wait_until(SEL_HEARD, 1'b1, 20, n);
    lit_check("after_abort_latency", n, 7);
    wait_until(SEL_BUZZER, 1'b1, 20, n);

    // asynchronous reset mid-response
    #3 rst = 1'b1;
    #1;
    lit_check("async_rst_buzzer", int'(buzzer_a), 0);
    lit_check("async_rst_busy", int'(busy_a), 0);
    lit_check("async_rst_busy_inv", int'(busy_b), 0);
    step();
    rst = 1'b0;
    repeat (40) step();

    // randomized phase
    en_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((mic_left == 0) && ($urandom_range(0, 14) == 0))
        pulse(int'($urandom_range(1, 12)));
      if (en_left > 0) begin
        en_left--;
        if (en_left == 0) enable = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        enable = 1'b0;
        en_left = int'($urandom_range(1, 6));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
